spi_master_arb: RTL and testbench
=================================

Name: spi_master_arb

Overview:
- Shared SPI master that serves NUM_REQ requesters. Each requester owns one slave-select line.
- Round-robin arbitration picks one request, then the block runs one full-duplex BITS_LEN-bit transfer: it generates spi_clk, drives MOSI, samples MISO, and returns the received word.
- Sits between on-chip clients and the board-level SPI bus that feeds the team's spi_slave endpoints.

Parameters:
BITS_LEN, 8, bits per transfer (>=2)
NUM_REQ, 2, number of requesters / slave selects (>=1)
CLK_DIV, 4, clk cycles per spi_clk half-period (>=2)
CPOL, 1'b0, spi_clk idle level
CPHA, 1'b0, 0 = sample on leading edge; 1 = sample on trailing edge

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request level
req_data  input  NUM_REQ*BITS_LEN  TX words; requester i uses slice [i*BITS_LEN +: BITS_LEN]
gnt  output  NUM_REQ  one-hot, one-cycle pulse; transfer accepted
done  output  NUM_REQ  one-hot, one-cycle pulse; rdata valid
rdata  output  BITS_LEN  last received word; held until next done
busy  output  1  high in every state except IDLE
spi_clk  output  1  SPI clock
spi_ss  output  NUM_REQ  active-low selects; at most one low
spi_mosi  output  1  serial out, MSB first
spi_miso  input  1  serial in, MSB first; sampled directly, board guarantees setup to sampling edge

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, done=0, rdata=0, busy=0, spi_clk=CPOL, spi_ss=all 1, spi_mosi=0, state=IDLE, round-robin pointer=0.
- FSM states: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
- IDLE:
  - On a clk edge with req!=0, the winner is the first set req bit at or after the pointer, searching with wrap-around.
  - Same edge: gnt[winner]=1 for one cycle, TX shift reg <= winner's req_data slice, spi_ss[winner]=0, pointer <= winner+1 mod NUM_REQ, state <= SETUP.
- req rules:
  - A requester holds req until it sees gnt; req_data is sampled only at the grant edge.
  - req dropped before grant means the request is withdrawn, with no side effects.
  - req changes after grant are ignored.
- SETUP: CLK_DIV cycles, spi_clk at CPOL. With CPHA=0, spi_mosi=MSB from the SETUP entry cycle.
- XFER:
  - Lasts 2*BITS_LEN*CLK_DIV cycles; spi_clk toggles every CLK_DIV cycles, giving 2*BITS_LEN edges (odd = leading, even = trailing).
  - CPHA=0: sample spi_miso into the RX shift reg on each leading edge; shift spi_mosi to the next bit on each trailing edge, except the last.
  - CPHA=1: drive the next TX bit (MSB first) on each leading edge; sample on each trailing edge.
  - After the last edge, spi_clk=CPOL.
- HOLD: CLK_DIV cycles, spi_ss still low, spi_clk=CPOL.
- GAP:
  - Entry edge: spi_ss = all 1, spi_mosi=0, rdata <= RX reg, done[winner]=1 for one cycle.
  - Lasts CLK_DIV cycles, then IDLE.
  - A request re-asserted or held during GAP is not granted before IDLE.
- Timing for grant at edge T:
  - spi_ss low for 2*CLK_DIV + 2*BITS_LEN*CLK_DIV cycles.
  - done at T + that value.
  - Earliest next grant at T + that value + CLK_DIV + 1.
  - Defaults: spi_ss low 72 cycles; grant-to-grant 77 cycles.
- Counters:
  - Half-period counter width = clog2(CLK_DIV), reloaded on each edge.
  - Edge counter width = clog2(2*BITS_LEN)+1.
  - Pointer width = clog2(NUM_REQ), or 1 bit when NUM_REQ=1.
- Reset mid-transfer: immediate return to reset values; no done for the aborted transfer; rdata=0.
- spi_ss is never low in IDLE or GAP. gnt and done never assert in the same cycle.

Test Plan:
1. Defaults, slave model returns 8'h3C; req[0]=1, req_data[7:0]=8'hA5 -> gnt=01 one cycle; spi_ss[0] low 72 cycles; MOSI at rising edges 1,0,1,0,0,1,0,1; exactly 8 rising spi_clk; done=01 with rdata=8'h3C at the spi_ss deassert cycle; spi_ss[1] stays high.
2. req=2'b11 held continuously from reset release -> grants alternate 01, 10, 01, each 77 cycles apart; requester 0 first; never two spi_ss low.
3. CPOL=1, CPHA=1, req_data=8'h81, slave returns 8'hFF -> spi_clk idles high; MOSI changes on falling edges (first falling edge drives 1); rdata=8'hFF; spi_ss timing same as scenario 1.
4. rst_n low at the 5th spi_clk edge of a transfer -> same cycle: spi_ss=11, spi_clk=CPOL, busy=0; no done pulse; next req is granted normally with full 72-cycle spi_ss low.
5. req[1] pulsed 1 cycle while busy, dropped before IDLE -> no gnt[1]. req_data[0] changed to 8'h00 the cycle after gnt[0] -> MOSI still shifts the originally sampled 8'hA5.
6. NUM_REQ=1, CLK_DIV=2, req held continuously -> grant-to-grant 2*2 + 32 + 2 + 1 = 39 cycles; done pulses between grants; pointer stays 0.

Source files
------------

// File: rtl/spi_master_arb.sv
// Shared SPI master: round-robin arbitration over NUM_REQ requesters, then one full-duplex
// BITS_LEN-bit transfer on the winner's slave select, returning the received word.
module spi_master_arb #(
  parameter int unsigned BITS_LEN = 8,
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned CLK_DIV  = 4,
  parameter logic        CPOL     = 1'b0,
  parameter logic        CPHA     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BITS_LEN-1:0]  req_data,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic [BITS_LEN-1:0]          rdata,
  output logic                         busy,
  output logic                         spi_clk,
  output logic [NUM_REQ-1:0]           spi_ss,
  output logic                         spi_mosi,
  input  logic                         spi_miso
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EdgeW = $clog2(2 * BITS_LEN) + 1;
  localparam int unsigned PtrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(2 * BITS_LEN);
  localparam logic [PtrW-1:0]  PtrLast  = PtrW'(NUM_REQ - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StGap} state_e;

  state_e               state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [EdgeW-1:0]     edge_q, edge_d, edge_nxt;
  logic [PtrW-1:0]      ptr_q, ptr_d, win_q, win_d;
  logic [BITS_LEN-1:0]  tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d, done_q, done_d, ss_q, ss_d;
  logic                 busy_q, busy_d, sclk_q, sclk_d, mosi_q, mosi_d;

  logic                 arb_found;
  logic [PtrW-1:0]      arb_win, arb_next;
  logic [BITS_LEN-1:0]  arb_data;
  logic [NUM_REQ-1:0]   arb_oh, win_oh;

  assign edge_nxt = edge_q + EdgeW'(1);

  // First set request at or after the pointer, then wrap around to the low indices.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && req[i] && (PtrW'(i) >= ptr_q)) begin
        arb_found = 1'b1;
        arb_win   = PtrW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && req[i]) begin
        arb_found = 1'b1;
        arb_win   = PtrW'(i);
      end
    end
    arb_data = '0;
    arb_oh   = '0;
    win_oh   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PtrW'(i) == arb_win) begin
        arb_data  = req_data[i*BITS_LEN +: BITS_LEN];
        arb_oh[i] = 1'b1;
      end
      if (PtrW'(i) == win_q) begin
        win_oh[i] = 1'b1;
      end
    end
    arb_next = (arb_win == PtrLast) ? '0 : arb_win + PtrW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (arb_found) state_d = StSetup;
      StSetup: if (div_q == '0) state_d = StXfer;
      StXfer:  if (div_q == '0 && edge_nxt == EdgeLast) state_d = StHold;
      StHold:  if (div_q == '0) state_d = StGap;
      StGap:   if (div_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    div_d   = (state_q == StIdle || div_q == '0) ? DivLast : div_q - DivW'(1);
    edge_d  = edge_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    gnt_d   = '0;
    done_d  = '0;
    rdata_d = rdata_q;
    busy_d  = (state_d != StIdle);
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    case (state_q)
      StIdle: begin
        if (arb_found) begin
          gnt_d  = arb_oh;
          ss_d   = ~arb_oh;
          tx_d   = arb_data;
          win_d  = arb_win;
          ptr_d  = arb_next;
          edge_d = '0;
          sclk_d = CPOL;
          mosi_d = CPHA ? 1'b0 : arb_data[BITS_LEN-1];
        end
      end
      StXfer: begin
        if (div_q == '0) begin
          edge_d = edge_nxt;
          sclk_d = ~sclk_q;
          if (edge_nxt[0]) begin
            // Leading edge
            if (!CPHA) begin
              rx_d = {rx_q[BITS_LEN-2:0], spi_miso};
            end else begin
              mosi_d = tx_q[BITS_LEN-1];
              tx_d   = {tx_q[BITS_LEN-2:0], 1'b0};
            end
          end else begin
            if (CPHA) begin
              rx_d = {rx_q[BITS_LEN-2:0], spi_miso};
            end else if (edge_nxt != EdgeLast) begin
              mosi_d = tx_q[BITS_LEN-2];
              tx_d   = {tx_q[BITS_LEN-2:0], 1'b0};
            end
          end
        end
      end
      StHold: begin
        if (div_q == '0) begin
          ss_d    = '1;
          mosi_d  = 1'b0;
          rdata_d = rx_q;
          done_d  = win_oh;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      edge_q  <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= CPOL;
      ss_q    <= '1;
      mosi_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      edge_q  <= edge_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign spi_clk  = sclk_q;
  assign spi_ss   = ss_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_arb.sv
// Bench for spi_master_arb: three instances (mode 0 default, CPOL=1/CPHA=1, single requester
// with CLK_DIV=2), each with a behavioural slave and a scoreboard of expected tx/rx words.
module tb_spi_master_arb;

  typedef struct packed {
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  // Instance 0: defaults
  logic        rst0_n, miso0, sclk0, mosi0, busy0;
  logic [1:0]  req0, gnt0, done0, ss0;
  logic [15:0] rd0;
  logic [7:0]  rdata0;
  // Instance 1: CPOL=1, CPHA=1
  logic        rst1_n, sclk1, mosi1, busy1;
  logic        miso1 = 1'b0;
  logic [1:0]  req1, gnt1, done1, ss1;
  logic [15:0] rd1;
  logic [7:0]  rdata1;
  // Instance 2: NUM_REQ=1, CLK_DIV=2
  logic        rst2_n, miso2, sclk2, mosi2, busy2;
  logic [0:0]  req2, gnt2, done2, ss2;
  logic [7:0]  rd2, rdata2;

  spi_master_arb u_dut0 (
    .clk(clk), .rst_n(rst0_n), .req(req0), .req_data(rd0), .gnt(gnt0), .done(done0),
    .rdata(rdata0), .busy(busy0), .spi_clk(sclk0), .spi_ss(ss0), .spi_mosi(mosi0),
    .spi_miso(miso0)
  );

  spi_master_arb #(.CPOL(1'b1), .CPHA(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .req(req1), .req_data(rd1), .gnt(gnt1), .done(done1),
    .rdata(rdata1), .busy(busy1), .spi_clk(sclk1), .spi_ss(ss1), .spi_mosi(mosi1),
    .spi_miso(miso1)
  );

  spi_master_arb #(.NUM_REQ(1), .CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .req(req2), .req_data(rd2), .gnt(gnt2), .done(done2),
    .rdata(rdata2), .busy(busy2), .spi_clk(sclk2), .spi_ss(ss2), .spi_mosi(mosi2),
    .spi_miso(miso2)
  );

  // Slave models and monitors, all evaluated on the falling clk edge.
  logic [7:0] sw0 = '0, sh0 = '0, cap0 = '0;
  logic [7:0] sw1 = '0, sh1 = '0, cap1 = '0;
  logic [7:0] sw2 = '0, sh2 = '0, cap2 = '0;
  logic       psclk0 = 1'b0, psclk1 = 1'b1, psclk2 = 1'b0;
  logic [1:0] seen0 = '0;
  int         rise0 = 0, rise1 = 0, rise2 = 0, sslow0 = 0, sslow1 = 0;
  int         ovl0 = 0, dcnt0 = 0, g1cnt0 = 0;
  wire        sel0 = ~&ss0;
  wire        sel1 = ~&ss1;
  wire        sel2 = ~ss2[0];

  assign miso0 = sh0[7];
  assign miso2 = sh2[7];

  always @(negedge clk) begin
    if (gnt0 != 2'b00) begin
      sh0 = sw0; cap0 = '0; rise0 = 0; sslow0 = 0; seen0 = '0;
    end else if (sel0 && psclk0 && !sclk0) begin
      sh0 = {sh0[6:0], 1'b0};
    end
    if (sel0 && !psclk0 && sclk0) begin
      cap0 = {cap0[6:0], mosi0}; rise0++;
    end
    psclk0 = sclk0;
    if (sel0) sslow0++;
    seen0 = seen0 | ~ss0;
    if ($countones(~ss0) > 1) ovl0++;
    if (done0 != 2'b00) dcnt0++;
    if (gnt0[1]) g1cnt0++;
  end

  always @(negedge clk) begin
    if (gnt1 != 2'b00) begin
      sh1 = sw1; cap1 = '0; rise1 = 0; sslow1 = 0;
    end else if (sel1 && psclk1 && !sclk1) begin
      miso1 = sh1[7]; sh1 = {sh1[6:0], 1'b0};
    end
    if (sel1 && !psclk1 && sclk1) begin
      cap1 = {cap1[6:0], mosi1}; rise1++;
    end
    psclk1 = sclk1;
    if (sel1) sslow1++;
  end

  always @(negedge clk) begin
    if (gnt2 != 1'b0) begin
      sh2 = sw2; cap2 = '0; rise2 = 0;
    end else if (sel2 && psclk2 && !sclk2) begin
      sh2 = {sh2[6:0], 1'b0};
    end
    if (sel2 && !psclk2 && sclk2) begin
      cap2 = {cap2[6:0], mosi2}; rise2++;
    end
    psclk2 = sclk2;
  end

  // Waits up to lim falling edges for the selected pulse; ok=0 on timeout.
  task automatic wait_evt(input int which, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      case (which)
        0: ok = (gnt0 != 2'b00);
        1: ok = (done0 != 2'b00);
        2: ok = (gnt1 != 2'b00);
        3: ok = (done1 != 2'b00);
        4: ok = (gnt2 != 1'b0);
        5: ok = (done2 != 1'b0);
        default: ok = 1'b0;
      endcase
    end
  endtask

  task automatic test_reset;
    rst0_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({gnt0, done0} !== 4'b0) begin bad++; $display("FAIL rst_gnt_done got=%b want=0", {gnt0, done0}); end
    total++; if (rdata0 !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h want=00", rdata0); end
    total++; if ({busy0, sclk0, mosi0} !== 3'b000) begin bad++; $display("FAIL rst_busy_clk_mosi got=%b want=000", {busy0, sclk0, mosi0}); end
    total++; if (ss0 !== 2'b11) begin bad++; $display("FAIL rst_ss got=%b want=11", ss0); end
    total++; if ({sclk1, ss1} !== 3'b111) begin bad++; $display("FAIL rst_cpol1 got=%b want=111", {sclk1, ss1}); end
    total++; if ({ss2, busy2} !== 2'b10) begin bad++; $display("FAIL rst_dut2 got=%b want=10", {ss2, busy2}); end
    rst0_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({busy0, ss0} !== 3'b011) begin bad++; $display("FAIL idle_no_req got=%b want=011", {busy0, ss0}); end
  endtask

  task automatic test_basic;
    bit ok; exp_t e; int unsigned tg;
    @(negedge clk);
    sw0 = 8'h3C; rd0 = 16'h00A5; req0 = 2'b01;
    sb0.push_back(exp_t'{tx: 8'hA5, rx: 8'h3C});
    wait_evt(0, 10, ok);
    tg = cyc; req0 = 2'b00;
    total++; if (!ok || gnt0 !== 2'b01) begin bad++; $display("FAIL basic_gnt got=%b want=01", gnt0); end
    @(negedge clk);
    total++; if ({gnt0, ss0, busy0} !== 5'b00101) begin bad++; $display("FAIL basic_gnt_pulse got=%b want=00101", {gnt0, ss0, busy0}); end
    wait_evt(1, 100, ok);
    e = sb0.pop_front();
    total++; if (!ok || done0 !== 2'b01) begin bad++; $display("FAIL basic_done got=%b want=01", done0); end
    total++; if (cyc - tg !== 72) begin bad++; $display("FAIL basic_done_lat got=%0d want=72", cyc - tg); end
    total++; if (rdata0 !== e.rx) begin bad++; $display("FAIL basic_rdata got=%h want=%h", rdata0, e.rx); end
    total++; if (cap0 !== e.tx) begin bad++; $display("FAIL basic_mosi got=%h want=%h", cap0, e.tx); end
    total++; if (rise0 !== 8) begin bad++; $display("FAIL basic_rises got=%0d want=8", rise0); end
    total++; if (sslow0 !== 72) begin bad++; $display("FAIL basic_ss_low got=%0d want=72", sslow0); end
    total++; if ({ss0, seen0} !== 4'b1101) begin bad++; $display("FAIL basic_ss_sel got=%b want=1101", {ss0, seen0}); end
    repeat (3) @(negedge clk);
    total++; if (rdata0 !== 8'h3C) begin bad++; $display("FAIL basic_rdata_hold got=%h want=3c", rdata0); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_round_robin;
    bit ok; exp_t e; int unsigned tp; int ovl_start;
    logic [1:0] eg [3];
    eg[0] = 2'b01; eg[1] = 2'b10; eg[2] = 2'b01;
    tp = 0;
    @(negedge clk);
    rst0_n = 1'b0; req0 = 2'b11; rd0 = 16'h5AA5; sw0 = 8'hC3;
    sb0.push_back(exp_t'{tx: 8'hA5, rx: 8'hC3});
    sb0.push_back(exp_t'{tx: 8'h5A, rx: 8'hC3});
    sb0.push_back(exp_t'{tx: 8'hA5, rx: 8'hC3});
    ovl_start = ovl0;
    @(negedge clk);
    rst0_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_evt(0, 100, ok);
      total++; if (!ok || gnt0 !== eg[k]) begin bad++; $display("FAIL rr_gnt%0d got=%b want=%b", k, gnt0, eg[k]); end
      if (k > 0) begin
        total++; if (cyc - tp !== 77) begin bad++; $display("FAIL rr_spacing%0d got=%0d want=77", k, cyc - tp); end
      end
      tp = cyc;
      if (k == 2) req0 = 2'b00;
      wait_evt(1, 100, ok);
      e = sb0.pop_front();
      total++; if (!ok || rdata0 !== e.rx || cap0 !== e.tx) begin bad++; $display("FAIL rr_xfer%0d got=%h/%h want=%h/%h", k, rdata0, cap0, e.rx, e.tx); end
    end
    total++; if (ovl0 !== ovl_start) begin bad++; $display("FAIL rr_two_ss_low got=%0d want=%0d", ovl0, ovl_start); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_mode3;
    bit ok; exp_t e; int unsigned tg;
    logic [7:0] tx [2]; logic [7:0] rx [2]; logic [1:0] rq [2];
    tx[0] = 8'h81; rx[0] = 8'hFF; rq[0] = 2'b01;
    tx[1] = 8'h3C; rx[1] = 8'hA6; rq[1] = 2'b10;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (sclk1 !== 1'b1) begin bad++; $display("FAIL m3_idle_clk%0d got=%b want=1", k, sclk1); end
      sw1 = rx[k]; rd1 = {tx[k], tx[k]}; req1 = rq[k];
      sb1.push_back(exp_t'{tx: tx[k], rx: rx[k]});
      wait_evt(2, 10, ok);
      tg = cyc; req1 = 2'b00;
      total++; if (!ok || gnt1 !== rq[k]) begin bad++; $display("FAIL m3_gnt%0d got=%b want=%b", k, gnt1, rq[k]); end
      wait_evt(3, 100, ok);
      e = sb1.pop_front();
      total++; if (!ok || done1 !== rq[k] || cyc - tg !== 72) begin bad++; $display("FAIL m3_done%0d got=%b@%0d want=%b@72", k, done1, cyc - tg, rq[k]); end
      total++; if (rdata1 !== e.rx || cap1 !== e.tx) begin bad++; $display("FAIL m3_data%0d got=%h/%h want=%h/%h", k, rdata1, cap1, e.rx, e.tx); end
      total++; if (sslow1 !== 72 || rise1 !== 8 || sclk1 !== 1'b1) begin bad++; $display("FAIL m3_timing%0d got=%0d/%0d/%b want=72/8/1", k, sslow1, rise1, sclk1); end
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    bit ok; exp_t e; int unsigned tg; int edges; int dstart; logic prev;
    @(negedge clk);
    sw0 = 8'h3C; rd0 = 16'h00A5; req0 = 2'b01;
    wait_evt(0, 10, ok);
    req0 = 2'b00; dstart = dcnt0; prev = sclk0; edges = 0;
    for (int i = 0; i < 100 && edges < 5; i++) begin
      @(negedge clk);
      if (sclk0 !== prev) begin edges++; prev = sclk0; end
    end
    total++; if (edges !== 5) begin bad++; $display("FAIL rm_edges got=%0d want=5", edges); end
    rst0_n = 1'b0;
    #1;
    total++; if ({ss0, sclk0, busy0} !== 4'b1100) begin bad++; $display("FAIL rm_abort got=%b want=1100", {ss0, sclk0, busy0}); end
    total++; if (rdata0 !== 8'h00) begin bad++; $display("FAIL rm_rdata got=%h want=00", rdata0); end
    @(negedge clk);
    rst0_n = 1'b1;
    repeat (100) @(negedge clk);
    total++; if (dcnt0 !== dstart) begin bad++; $display("FAIL rm_no_done got=%0d want=%0d", dcnt0, dstart); end
    sw0 = 8'h5A; rd0 = 16'h9600; req0 = 2'b10;
    sb0.push_back(exp_t'{tx: 8'h96, rx: 8'h5A});
    wait_evt(0, 10, ok);
    tg = cyc; req0 = 2'b00;
    total++; if (!ok || gnt0 !== 2'b10) begin bad++; $display("FAIL rm_regnt got=%b want=10", gnt0); end
    wait_evt(1, 100, ok);
    e = sb0.pop_front();
    total++; if (!ok || done0 !== 2'b10 || cyc - tg !== 72 || sslow0 !== 72) begin bad++; $display("FAIL rm_redone got=%b@%0d ss=%0d want=10@72 ss=72", done0, cyc - tg, sslow0); end
    total++; if (rdata0 !== e.rx || cap0 !== e.tx || seen0 !== 2'b10) begin bad++; $display("FAIL rm_data got=%h/%h/%b want=%h/%h/10", rdata0, cap0, seen0, e.rx, e.tx); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_withdraw;
    bit ok; exp_t e; int g1start;
    @(negedge clk);
    g1start = g1cnt0;
    sw0 = 8'h3C; rd0 = 16'h00A5; req0 = 2'b01;
    sb0.push_back(exp_t'{tx: 8'hA5, rx: 8'h3C});
    wait_evt(0, 10, ok);
    req0 = 2'b00;
    total++; if (!ok || gnt0 !== 2'b01) begin bad++; $display("FAIL wd_gnt got=%b want=01", gnt0); end
    @(negedge clk);
    rd0 = 16'h0000;
    repeat (10) @(negedge clk);
    req0 = 2'b10;
    @(negedge clk);
    req0 = 2'b00;
    wait_evt(1, 100, ok);
    e = sb0.pop_front();
    req0 = 2'b10;
    total++; if (!ok || cap0 !== e.tx || rdata0 !== e.rx) begin bad++; $display("FAIL wd_sampled got=%h/%h want=%h/%h", cap0, rdata0, e.tx, e.rx); end
    @(negedge clk);
    req0 = 2'b00;
    repeat (10) @(negedge clk);
    total++; if (g1cnt0 !== g1start || busy0 !== 1'b0) begin bad++; $display("FAIL wd_no_gnt1 got=%0d/%b want=%0d/0", g1cnt0, busy0, g1start); end
  endtask

  task automatic test_single_req;
    bit ok; exp_t e; int unsigned tp;
    tp = 0;
    @(negedge clk);
    sw2 = 8'h96; rd2 = 8'h69; req2 = 1'b1;
    for (int k = 0; k < 3; k++) sb2.push_back(exp_t'{tx: 8'h69, rx: 8'h96});
    for (int k = 0; k < 3; k++) begin
      wait_evt(4, 60, ok);
      total++; if (!ok || gnt2 !== 1'b1) begin bad++; $display("FAIL sr_gnt%0d got=%b want=1", k, gnt2); end
      if (k > 0) begin
        total++; if (cyc - tp !== 39) begin bad++; $display("FAIL sr_spacing%0d got=%0d want=39", k, cyc - tp); end
      end
      tp = cyc;
      if (k == 2) req2 = 1'b0;
      wait_evt(5, 60, ok);
      e = sb2.pop_front();
      total++; if (!ok || cyc - tp !== 36) begin bad++; $display("FAIL sr_done%0d got=%0d want=36", k, cyc - tp); end
      total++; if (rdata2 !== e.rx || cap2 !== e.tx || rise2 !== 8) begin bad++; $display("FAIL sr_data%0d got=%h/%h/%0d want=%h/%h/8", k, rdata2, cap2, rise2, e.rx, e.tx); end
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst0_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1;
    req0 = '0; req1 = '0; req2 = '0;
    rd0 = '0; rd1 = '0; rd2 = '0;
    #1;
    test_reset();
    test_basic();
    test_round_robin();
    test_mode3();
    test_reset_mid();
    test_withdraw();
    test_single_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
